// File: rtl/share_pipe.sv
// Elastic pipeline carrying SHARES independent Boolean shares per word, with
// bubble collapsing, synchronous flush and a registered occupancy count.
module share_pipe #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SHARES = 2,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHARES*WIDTH-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHARES*WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int unsigned DW = SHARES * WIDTH;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [OW-1:0]    occ_q;

    logic [DEPTH-1:0] take;
    logic [DEPTH-1:0] vacate;
    logic [DEPTH-1:0] load;
    logic             room;
    logic             in_xfer;
    logic             out_xfer;

    // Walk from the output back to the input: a stage can take a new word if it
    // is empty or its current word moves on in the same cycle.
    always_comb begin
        take   = '0;
        vacate = '0;
        room   = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            vacate[k] = valid_q[k] && room;
            take[k]   = !valid_q[k] || room;
            room      = take[k];
        end
    end

    assign in_ready  = take[0] && !flush && rst_n;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = valid_q[DEPTH-1];
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = data_q[DEPTH-1];
    assign occupancy = occ_q;

    always_comb begin
        load    = '0;
        load[0] = in_xfer;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = valid_q[k-1] && take[k];
        end
        valid_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = load[k] || (valid_q[k] && !vacate[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (in_xfer && !out_xfer) begin
                occ_q <= occ_q + OW'(1);
            end else if (!in_xfer && out_xfer) begin
                occ_q <= occ_q - OW'(1);
            end
        end
    end

    // Shares travel as an opaque word: each register only ever copies its
    // upstream neighbour, so no share is ever mixed with another.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
        end else begin
            if (load[0]) data_q[0] <= in_data;
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) data_q[k] <= data_q[k-1];
            end
        end
    end

endmodule
